j1_uart_tx: RTL

- Memory-mapped UART transmitter on the TOP_J1 I/O bus, giving the J1 core a serial output path.
- The CPU writes bytes through the io write strobe. They queue in an internal FIFO and are serialised 8N1, LSB first, on `uart_txd`.
- The CPU polls a status register through the io read strobe for busy, full, empty and overflow.
- Sits beside the core inside TOP_J1, driven by the same 100 MHz `clk` and `rst_n`.

---
 rtl/j1_uart_tx_if.sv | 28 ++
 rtl/j1_uart_tx.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/j1_uart_tx_if.sv
// I/O bus between the J1 core and the UART transmitter.
// The CPU drives the master side and the peripheral answers on the slave side.
interface j1_uart_tx_if;
    logic        io_wr;
    logic        io_rd;
    logic [15:0] io_addr;
    logic [15:0] io_dout;
    logic [15:0] io_din;
    logic        io_din_vld;

    modport master (
        output io_wr,
        output io_rd,
        output io_addr,
        output io_dout,
        input  io_din,
        input  io_din_vld
    );

    modport slave (
        input  io_wr,
        input  io_rd,
        input  io_addr,
        input  io_dout,
        output io_din,
        output io_din_vld
    );
endinterface

// File: rtl/j1_uart_tx.sv
// Memory-mapped 8N1 UART transmitter for the J1 I/O bus: DATA register feeds a
// circular FIFO that a four-state shifter drains onto a registered serial line.
module j1_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter logic [15:0] BASE_ADDR    = 16'h1000
) (
    input  logic              clk,
    input  logic              rst_n,
    j1_uart_tx_if.slave       io_bus,
    output logic              uart_txd,
    output logic              tx_busy
);

    localparam int unsigned AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW        = AW + 1;
    localparam logic [15:0] STAT_ADDR = BASE_ADDR + 16'd2;
    localparam logic [15:0] CNT_MAX   = 16'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH_V = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic [15:0]   r_din;
    logic          r_din_vld;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [15:0]   r_bit_cnt;
    logic [15:0]   w_bit_cnt_nxt;
    logic [2:0]    r_idx;
    logic [2:0]    w_idx_nxt;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_nxt;
    logic          r_txd;
    logic          w_txd_nxt;
    logic          r_busy;

    logic          w_data_wr;
    logic          w_stat_wr;
    logic          w_stat_rd;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_cnt_done;
    logic [2:0]    w_idx_inc;
    logic [7:0]    w_head;
    logic [8:0]    w_occ;

    assign w_data_wr  = io_bus.io_wr && (io_bus.io_addr == BASE_ADDR);
    assign w_stat_wr  = io_bus.io_wr && (io_bus.io_addr == STAT_ADDR);
    assign w_stat_rd  = io_bus.io_rd && (io_bus.io_addr == STAT_ADDR);
    assign w_full     = (r_count == DEPTH_V);
    assign w_empty    = (r_count == CW'(0));
    // Fullness is judged on the registered count, so a same-cycle pop never frees room.
    assign w_push     = w_data_wr && !w_full;
    assign w_cnt_done = (r_bit_cnt == CNT_MAX);
    assign w_idx_inc  = r_idx + 3'd1;
    assign w_head     = r_mem[r_rptr];
    assign w_occ      = 9'(r_count);

    // FIFO storage; data needs no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= io_bus.io_dout[7:0];
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_data_wr && w_full) begin
                r_ovf <= 1'b1;
            end else if (w_stat_wr && io_bus.io_dout[3]) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // STATUS read port: snapshot of pre-update state, held until the next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_din     <= 16'h0000;
            r_din_vld <= 1'b0;
        end else begin
            r_din_vld <= w_stat_rd;
            if (w_stat_rd) begin
                r_din <= {3'b000, w_occ, r_ovf, w_empty, w_full, r_busy};
            end
        end
    end

    // Shifter next state; the line level is computed for the next state so it registers in step.
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_idx_nxt     = r_idx;
        w_shift_nxt   = r_shift;
        w_txd_nxt     = 1'b1;
        w_pop         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop         = 1'b1;
                    w_shift_nxt   = w_head;
                    w_bit_cnt_nxt = 16'd0;
                    w_state_nxt   = ST_START;
                    w_txd_nxt     = 1'b0;
                end else begin
                    w_txd_nxt     = 1'b1;
                end
            end
            ST_START: begin
                if (w_cnt_done) begin
                    w_bit_cnt_nxt = 16'd0;
                    w_idx_nxt     = 3'd0;
                    w_state_nxt   = ST_DATA;
                    w_txd_nxt     = r_shift[0];
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + 16'd1;
                    w_txd_nxt     = 1'b0;
                end
            end
            ST_DATA: begin
                if (w_cnt_done) begin
                    w_bit_cnt_nxt = 16'd0;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = ST_STOP;
                        w_txd_nxt   = 1'b1;
                    end else begin
                        w_idx_nxt   = w_idx_inc;
                        w_txd_nxt   = r_shift[w_idx_inc];
                    end
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + 16'd1;
                    w_txd_nxt     = r_shift[r_idx];
                end
            end
            ST_STOP: begin
                if (w_cnt_done) begin
                    w_bit_cnt_nxt = 16'd0;
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_head;
                        w_state_nxt = ST_START;
                        w_txd_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_txd_nxt   = 1'b1;
                    end
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + 16'd1;
                    w_txd_nxt     = 1'b1;
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_bit_cnt_nxt = 16'd0;
                w_txd_nxt     = 1'b1;
            end
        endcase
    end

    // Shifter state register with registered line and busy outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= 16'd0;
            r_idx     <= 3'd0;
            r_shift   <= 8'h00;
            r_txd     <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_txd     <= w_txd_nxt;
            r_busy    <= (w_state_nxt != ST_IDLE);
        end
    end

    assign uart_txd          = r_txd;
    assign tx_busy           = r_busy;
    assign io_bus.io_din     = r_din;
    assign io_bus.io_din_vld = r_din_vld;

endmodule
